// File: rtl/uart_rx_ctrl_pkg.sv
// uart_rx_ctrl_pkg: shared definitions for the UART receive path.
// Holds the receiver FSM encoding, the bit-period helper and the 8N1 frame
// constants that are common with the transmit controller.
package uart_rx_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   // 8N1 framing
   localparam int START_BITS = 1;
   localparam int DATA_BITS  = 8;
   localparam int STOP_BITS  = 1;
   localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;

   // Clocks per bit, truncated (86 for 10 MHz / 115200).
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: serial input plus received byte/word outputs.
//   rx         - UART serial line, idle high
//   rx_reg     - last completed word
//   rx_dv      - one-cycle strobe, rx_reg updated
//   rx_byte    - last good byte
//   rx_byte_dv - one-cycle strobe per good byte
//   frame_err  - one-cycle strobe, stop bit sampled low
//   rx_busy    - frame in progress
// master: the receive controller; slave: the host/line side.
interface uart_rx_ctrl_if #(
   parameter int WORD_BYTES = 8
);
   logic                      rx;
   logic [WORD_BYTES*8-1:0]   rx_reg;
   logic                      rx_dv;
   logic [7:0]                rx_byte;
   logic                      rx_byte_dv;
   logic                      frame_err;
   logic                      rx_busy;

   modport master (
      input  rx,
      output rx_reg, rx_dv, rx_byte, rx_byte_dv, frame_err, rx_busy
   );

   modport slave (
      output rx,
      input  rx_reg, rx_dv, rx_byte, rx_byte_dv, frame_err, rx_busy
   );
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver.
// Synchronises rx, detects the start edge, samples each bit at mid-bit and
// reports the outcome of the stop-bit sample.
//   clk, rst   - clock, async active-low reset
//   rx         - raw serial input
//   data       - assembled shift register (valid with data_ok)
//   data_ok    - stop bit sampled high this cycle
//   data_bad   - stop bit sampled low this cycle
//   start_edge - falling edge of rx_s seen while idle
//   busy       - FSM not in IDLE
module uart_rx_byte
   import uart_rx_ctrl_pkg::*;
#(
   parameter int CLKS_PER_BIT = 86
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_ok,
   output logic       data_bad,
   output logic       start_edge,
   output logic       busy
);

   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT/2 - 1);
   localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

   logic       rx_m, rx_s, rx_prev;
   rx_state_e  state;
   logic [15:0] cnt;
   logic [2:0] bit_idx;
   logic [7:0] shift;

   // Two-flop synchroniser; flops reset to the idle (high) line level so a
   // release of reset never looks like a start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_m    <= rx;
         rx_s    <= rx_m;
         rx_prev <= rx_s;
      end
   end

   assign start_edge = (state == IDLE) && rx_prev && !rx_s;
   assign data_ok    = (state == STOP) && (cnt == FULL_LAST) && rx_s;
   assign data_bad   = (state == STOP) && (cnt == FULL_LAST) && !rx_s;
   assign data       = shift;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_edge) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  // High at mid start bit means a glitch, not a frame.
                  state   <= rx_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DATA: begin
               if (cnt == FULL_LAST) begin
                  cnt     <= '0;
                  shift   <= {rx_s, shift[7:1]};  // LSB first
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == LAST_BIT) state <= STOP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            STOP: begin
               // Leave at mid stop bit; a low stop bit (break) leaves
               // rx_prev low, so no false start follows.
               if (cnt == FULL_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller. Receives 8N1 bytes and packs
// WORD_BYTES of them into one word, first byte in the most significant
// position. A partial word is dropped after TIMEOUT_CLKS idle clocks or on a
// framing error.
//   clk, rst - clock (clk_10), async active-low reset
//   bus      - uart_rx_ctrl_if master: rx in; rx_reg/rx_dv, rx_byte/rx_byte_dv,
//              frame_err, rx_busy out (all registered)
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int CLK_FREQ     = 10000000,
   parameter int BAUD         = 115200,
   parameter int WORD_BYTES   = 8,
   parameter int TIMEOUT_CLKS = 100000
) (
   input  logic          clk,
   input  logic          rst,
   uart_rx_ctrl_if.master bus
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int W  = WORD_BYTES * 8;
   localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WORD_BYTES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 1);

   logic [7:0]     data;
   logic           data_ok, data_bad, start_edge, busy;

   logic [W-1:0]   word, rx_reg;
   logic [W+7:0]   word_cat;
   logic [CW-1:0]  byte_cnt;
   logic [TW-1:0]  idle_cnt;
   logic [7:0]     rx_byte;
   logic           rx_dv, rx_byte_dv, frame_err, rx_busy;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
      .clk        (clk),
      .rst        (rst),
      .rx         (bus.rx),
      .data       (data),
      .data_ok    (data_ok),
      .data_bad   (data_bad),
      .start_edge (start_edge),
      .busy       (busy)
   );

   // New byte enters at the low end; the top byte falls off.
   assign word_cat = {word, data};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word       <= '0;
         rx_reg     <= '0;
         byte_cnt   <= '0;
         idle_cnt   <= '0;
         rx_byte    <= '0;
         rx_dv      <= 1'b0;
         rx_byte_dv <= 1'b0;
         frame_err  <= 1'b0;
         rx_busy    <= 1'b0;
      end else begin
         rx_dv      <= 1'b0;
         rx_byte_dv <= 1'b0;
         frame_err  <= 1'b0;
         rx_busy    <= busy;
         if (data_ok) begin
            rx_byte    <= data;
            rx_byte_dv <= 1'b1;
            word       <= word_cat[W-1:0];
            idle_cnt   <= '0;
            if (byte_cnt == CNT_LAST) begin
               rx_reg   <= word_cat[W-1:0];
               rx_dv    <= 1'b1;
               byte_cnt <= '0;
            end else begin
               byte_cnt <= byte_cnt + 1'b1;
            end
         end else if (data_bad) begin
            frame_err <= 1'b1;
            byte_cnt  <= '0;
            idle_cnt  <= '0;
         end else if (start_edge) begin
            // Start edge wins over a coincident timeout; count kept.
            idle_cnt <= '0;
         end else if (byte_cnt != '0 && !busy) begin
            if (idle_cnt == TO_LAST) begin
               byte_cnt <= '0;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end else begin
            idle_cnt <= '0;
         end
      end
   end

   // rx_busy is the FSM state delayed one clock, aligned with the other
   // registered outputs.
   assign bus.rx_reg     = rx_reg;
   assign bus.rx_dv      = rx_dv;
   assign bus.rx_byte    = rx_byte;
   assign bus.rx_byte_dv = rx_byte_dv;
   assign bus.frame_err  = frame_err;
   assign bus.rx_busy    = rx_busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl (86 clks/bit, short
// timeout so the run stays small).
module tb_uart_rx_ctrl;

   localparam int CPB = 86;
   localparam int TO  = 2000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   uart_rx_ctrl_if #(.WORD_BYTES(8)) ifc ();

   uart_rx_ctrl #(
      .CLK_FREQ(10000000), .BAUD(115200), .WORD_BYTES(8), .TIMEOUT_CLKS(TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #50 clk = ~clk;

   // Event monitor, sampled on the falling edge.
   logic [7:0]  bytes_q[$];
   logic [63:0] last_word = '0;
   int dv_cnt = 0, fe_cnt = 0, lone_dv = 0;

   always @(negedge clk) begin
      if (rst) begin
         if (ifc.rx_byte_dv) bytes_q.push_back(ifc.rx_byte);
         if (ifc.rx_dv) begin
            dv_cnt++;
            last_word = ifc.rx_reg;
            if (!ifc.rx_byte_dv) lone_dv++;
         end
         if (ifc.frame_err) fe_cnt++;
      end
   end

   task automatic idle(input int n);
      ifc.rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      ifc.rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         ifc.rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      ifc.rx = stop;
      repeat (CPB) @(negedge clk);
      ifc.rx = 1'b1;
      if (!stop) repeat (CPB) @(negedge clk);
   endtask

   task automatic test_reset();
      ifc.rx = 1'b1;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      idle(2000);
      checks++;
      if (ifc.rx_reg !== 64'h0) begin
         errors++; $display("FAIL reset_rx_reg got=%h exp=0", ifc.rx_reg);
      end
      checks++;
      if ({ifc.rx_dv, ifc.rx_byte_dv, ifc.frame_err, ifc.rx_busy} !== 4'b0) begin
         errors++;
         $display("FAIL reset_strobes got=%b exp=0000",
                  {ifc.rx_dv, ifc.rx_byte_dv, ifc.frame_err, ifc.rx_busy});
      end
      checks++;
      if (ifc.rx_byte !== 8'h0) begin
         errors++; $display("FAIL reset_rx_byte got=%h exp=0", ifc.rx_byte);
      end
      checks++;
      if (bytes_q.size() != 0 || dv_cnt != 0 || fe_cnt != 0) begin
         errors++;
         $display("FAIL reset_no_events bytes=%0d dv=%0d fe=%0d exp=0",
                  bytes_q.size(), dv_cnt, fe_cnt);
      end
   endtask

   // Send 8 bytes base, base+step, ... and check the assembled word.
   task automatic send_word_check(input string nm, input logic [7:0] base,
                                  input logic [7:0] step);
      int b0 = bytes_q.size();
      int d0 = dv_cnt;
      int l0 = lone_dv;
      logic [63:0] exp = '0;
      for (int i = 0; i < 8; i++) begin
         logic [7:0] v = base + step * 8'(i);
         exp = {exp[55:0], v};
         send_byte(v, 1'b1);
      end
      idle(20);
      checks++;
      if (bytes_q.size() - b0 != 8) begin
         errors++;
         $display("FAIL %s_byte_count got=%0d exp=8", nm, bytes_q.size() - b0);
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (bytes_q[b0+i] !== exp[63-8*i -: 8]) begin
               errors++;
               $display("FAIL %s_byte%0d got=%h exp=%h", nm, i,
                        bytes_q[b0+i], exp[63-8*i -: 8]);
            end
         end
      end
      checks++;
      if (dv_cnt - d0 != 1) begin
         errors++; $display("FAIL %s_dv_count got=%0d exp=1", nm, dv_cnt - d0);
      end
      checks++;
      if (last_word !== exp) begin
         errors++; $display("FAIL %s_rx_reg got=%h exp=%h", nm, last_word, exp);
      end
      checks++;
      if (lone_dv != l0) begin
         errors++;
         $display("FAIL %s_dv_coincident lone=%0d exp=%0d", nm, lone_dv, l0);
      end
   endtask

   task automatic test_word();
      int f0 = fe_cnt;
      send_word_check("word", 8'h01, 8'h01);
      checks++;
      if (fe_cnt != f0) begin
         errors++; $display("FAIL word_no_ferr got=%0d exp=%0d", fe_cnt, f0);
      end
      checks++;
      if (ifc.rx_busy !== 1'b0) begin
         errors++; $display("FAIL word_busy_after got=%b exp=0", ifc.rx_busy);
      end
   endtask

   task automatic test_glitch();
      int b0 = bytes_q.size();
      int f0 = fe_cnt;
      ifc.rx = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (ifc.rx_busy !== 1'b1) begin
         errors++; $display("FAIL glitch_busy got=%b exp=1", ifc.rx_busy);
      end
      repeat (10) @(negedge clk);
      idle(100);
      checks++;
      if (ifc.rx_busy !== 1'b0) begin
         errors++; $display("FAIL glitch_back_idle got=%b exp=0", ifc.rx_busy);
      end
      checks++;
      if (bytes_q.size() != b0 || fe_cnt != f0) begin
         errors++;
         $display("FAIL glitch_no_events bytes=%0d fe=%0d exp=%0d,%0d",
                  bytes_q.size(), fe_cnt, b0, f0);
      end
   endtask

   task automatic test_frame_err();
      int b0 = bytes_q.size();
      int f0 = fe_cnt;
      send_byte(8'hA5, 1'b0);
      idle(20);
      checks++;
      if (fe_cnt - f0 != 1) begin
         errors++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt - f0);
      end
      checks++;
      if (bytes_q.size() != b0) begin
         errors++;
         $display("FAIL ferr_no_byte got=%0d exp=0", bytes_q.size() - b0);
      end
      send_word_check("after_ferr", 8'h11, 8'h11);
   endtask

   // A partial word followed by a short gap must still complete.
   task automatic test_no_timeout();
      int d0 = dv_cnt;
      send_byte(8'h5A, 1'b1);
      send_byte(8'h6B, 1'b1);
      send_byte(8'h7C, 1'b1);
      idle(TO - 200);
      for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i), 1'b1);
      idle(20);
      checks++;
      if (dv_cnt - d0 != 1 || last_word !== 64'h5A6B7CE0E1E2E3E4) begin
         errors++;
         $display("FAIL no_timeout_word got=%h dv=%0d exp=5a6b7ce0e1e2e3e4 dv=1",
                  last_word, dv_cnt - d0);
      end
   endtask

   task automatic test_timeout();
      int d0 = dv_cnt;
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      send_byte(8'hCC, 1'b1);
      idle(TO + 10);
      checks++;
      if (dv_cnt != d0) begin
         errors++; $display("FAIL timeout_no_dv got=%0d exp=0", dv_cnt - d0);
      end
      send_word_check("timeout", 8'hF0, 8'h01);
   endtask

   task automatic test_reset_mid();
      send_byte(8'h3C, 1'b1);
      send_byte(8'h5A, 1'b1);
      ifc.rx = 1'b0;
      repeat (CPB) @(negedge clk);
      ifc.rx = 1'b1;
      repeat (CPB) @(negedge clk);
      ifc.rx = 1'b0;
      repeat (CPB + 20) @(negedge clk);
      ifc.rx = 1'b1;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (ifc.rx_busy !== 1'b0 || ifc.rx_reg !== 64'h0) begin
         errors++;
         $display("FAIL rst_mid_clear busy=%b reg=%h exp=0", ifc.rx_busy, ifc.rx_reg);
      end
      rst = 1'b1;
      idle(50);
      checks++;
      if (ifc.rx_busy !== 1'b0) begin
         errors++; $display("FAIL rst_mid_idle got=%b exp=0", ifc.rx_busy);
      end
      send_word_check("rst_mid", 8'hC0, 8'h01);
   endtask

   initial begin
      ifc.rx = 1'b1;
      test_reset();
      test_word();
      test_glitch();
      test_frame_err();
      test_no_timeout();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side counterpart of the board's UART transmit controller: deserialises 8N1 UART frames from the RX pin and assembles WORD_BYTES bytes into one wide word.
- Issues a one-cycle data-valid strobe per completed word, giving the host a command/config path back into the RRAM controller.
- Sits in the 10 MHz clk_10 domain beside the transmit controller; the RX pin is asynchronous to it.

Parameters:
- CLK_FREQ, 10000000, clock frequency in Hz.
- BAUD, 115200, line rate. Derived constant CLKS_PER_BIT = CLK_FREQ/BAUD (truncated; 86 at defaults).
- WORD_BYTES, 8, bytes per assembled word (1..8); rx_reg width is WORD_BYTES*8.
- TIMEOUT_CLKS, 100000, idle clocks after which a partial word is discarded.

Ports:
- clk  input  1  system clock (clk_10).
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  UART serial input, idle high, asynchronous to clk.
- rx_reg  output  WORD_BYTES*8  last completed word.
- rx_dv  output  1  one-cycle strobe: rx_reg updated this cycle.
- rx_byte  output  8  last good byte.
- rx_byte_dv  output  1  one-cycle strobe per good byte.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.
- rx_busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst low, async): all outputs 0, state IDLE, byte count 0, counters 0, both synchroniser flops set to 1 (idle line).
- rx passes through a 2-flop synchroniser. All logic uses the synchronised value rx_s; the previous rx_s is kept for edge detection.
- FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on a falling edge of rx_s; the bit counter clears.
- START: count to CLKS_PER_BIT/2 - 1 (mid start bit).
  - rx_s low: go to DATA, counter clears.
  - rx_s high: glitch; return to IDLE, nothing emitted.
- DATA: sample rx_s every CLKS_PER_BIT clocks at mid-bit, LSB first, into the shift register. After the 8th sample go to STOP.
- STOP: sample at mid stop bit, then return to IDLE the same cycle. The line is high, so no false start occurs.
  - rx_s high: rx_byte <= shift register, rx_byte_dv = 1 for one cycle.
  - rx_s low: frame_err = 1 for one cycle; the byte is dropped and the word byte count resets to 0.
- Word assembly:
  - Each good byte shifts in at the low end: rx word <= {word[W-9:0], byte}. The first byte received ends up in the most significant byte.
  - When byte count reaches WORD_BYTES - 1 and a good byte arrives, rx_reg loads the completed word, rx_dv pulses in the same cycle as that byte's rx_byte_dv, and the count wraps to 0.
  - rx_reg holds its value between words.
- Latency: rx_byte_dv is asserted 1 cycle after the mid-stop sample clock. Relative to the start edge at the pin, that is roughly 2 + 9.5*CLKS_PER_BIT clocks.
- Timeout:
  - The idle counter runs only while byte count != 0 and state == IDLE.
  - It clears on any start edge.
  - On reaching TIMEOUT_CLKS, byte count <= 0 and the partial word is discarded. No strobe is issued.
- Simultaneous events: a timeout and a start edge in the same cycle are resolved in favour of the start edge; the count is preserved.
- Reset mid-frame aborts immediately. After release, reception resumes only on the next falling edge.
- A continuous-low (break) line produces one frame_err, then waits in IDLE for a high-to-low transition.

Decomposition:
- Shared package/include holds:
  - the FSM state encoding (2-bit: IDLE=0, START=1, DATA=2, STOP=3);
  - the CLKS_PER_BIT computation function;
  - the 8N1 frame constants, common with the transmit controller.
- One natural sub-module, uart_rx_byte: synchroniser, FSM and bit sampling, producing byte/byte_dv/frame_err.
- The top of uart_rx_ctrl adds word assembly and the timeout.

Test Plan:
- Reset, then rx idle high for 2000 clks -> all outputs 0, rx_busy 0.
- Send bytes 0x01..0x08 at 86 clks/bit, back-to-back -> 8 rx_byte_dv pulses with rx_byte=0x01..0x08. rx_dv pulses once with rx_reg=0x0102030405060708, coincident with the 8th rx_byte_dv.
- 20-clk low glitch on idle rx -> FSM returns to IDLE from START; no rx_byte_dv, no frame_err.
- Send 0xA5 with stop bit driven low -> frame_err one pulse, no rx_byte_dv. Then 8 good bytes 0x11..0x88 -> rx_reg=0x1122334455667788.
- Send 3 bytes, idle for TIMEOUT_CLKS+10, then send 0xF0..0xF7 -> rx_reg=0xF0F1F2F3F4F5F6F7; the first 3 bytes are absent from rx_reg.
- Assert rst low mid-DATA of a byte, release, send 8 bytes 0xC0..0xC7 -> rx_reg=0xC0C1C2C3C4C5C6C7, exactly one rx_dv.
